mem_master: RTL and testbench
=============================

# mem_master

Bus initiator driving the byte-wide RAM read/write/ready port. Accepts single-request byte or 16-bit load/store commands from the CPU side. Issues one-cycle `read`/`write` strobes to the RAM, waits for `ready_r`/`ready_w`, and returns assembled read data with a one-cycle response pulse. 16-bit accesses are split into two little-endian byte transactions.

## Interface
Parameters:
- `size_addr`, 8: RAM address width. Address arithmetic is modulo 2^size_addr.
- `timeout`, 15: maximum cycles spent waiting for ready per byte transaction. Used only with `MEM_MASTER_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  master idle; request accepted when `req_valid && req_ready` at an edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_wide`  in  1  1 = 16-bit access, 0 = byte.
- `req_addr`  in  size_addr  byte address of the low byte.
- `req_wdata`  in  16  store data; byte stores use [7:0].
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  16  load data, stable from `rsp_valid` until the next `rsp_valid`.
- `rsp_err`  out  1  timeout abort flag, qualified by `rsp_valid`.
- `mem_read`  out  1  RAM read strobe.
- `mem_write`  out  1  RAM write strobe.
- `mem_address`  out  size_addr  RAM address.
- `mem_wdata`  out  8  to RAM `data_in`.
- `mem_rdata`  in  8  from RAM `data_out`.
- `mem_ready_r`  in  1  RAM read done.
- `mem_ready_w`  in  1  RAM write done.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- **Reset values:** state IDLE, `req_ready`=1; all other outputs are 0.
- **IDLE:**
  - `req_ready`=1.
  - On accept, latch `req_we`, `req_wide`, `req_addr`, `req_wdata`, clear the byte index, then go to ISSUE.
  - Request inputs are ignored after acceptance.
- **ISSUE:**
  - Exactly one cycle with `mem_read`=!we or `mem_write`=we.
  - `mem_address` = addr + index, with wrap (0xFF+1 → 0x00 at `size_addr`=8).
  - `mem_wdata` = wdata[7:0] for index 0, wdata[15:8] for index 1.
  - Then go to WAIT; strobes deassert.
- **WAIT:**
  - Hold `mem_address`/`mem_wdata`.
  - Only the ready matching the issued operation counts; the other ready and any ready outside WAIT are ignored.
  - On ready for a load, capture `mem_rdata` into byte lane [index].
  - If wide and index==0: set index=1 and go to ISSUE.
  - Otherwise go to RESP.
- **RESP:**
  - `rsp_valid`=1 for one cycle.
  - Byte load: `rsp_rdata`={8'h00, byte}. Wide load: {hi, lo}.
  - Stores leave `rsp_rdata` unchanged.
  - Then go to IDLE.
- **Reset mid-operation:** outputs go to reset values immediately (asynchronous). A strobe in flight is dropped, and no response is issued.

## Timing
- **Accept edge E0:**
  - Strobe high during E0–E1.
  - RAM asserts ready after E1.
  - Master samples ready at E2.
  - `rsp_valid` high E2–E3 (byte).
  - `req_ready` high again from E3.
- **Wide access:**
  - High-byte strobe E2–E3, ready sampled at E4.
  - `rsp_valid` E4–E5; `req_ready` from E5.
- **Throughput:** byte access one per 4 cycles; wide access one per 6 cycles.
- A `req_valid` held through RESP is not accepted until `req_ready` reasserts.

## Configuration
- `MEM_MASTER_TIMEOUT_EN` defined:
  - A WAIT-cycle counter clears on entry to WAIT.
  - If it reaches `timeout` without a matching ready, abort to RESP with `rsp_err`=1 and `rsp_rdata`=16'h0000.
  - Any remaining high byte is not issued.
- Not defined:
  - No counter; WAIT holds indefinitely.
  - `rsp_err` is tied 0.

## Test plan
- **Byte store then load:** store 0xA5 to 0x10, then load 0x10.
  - One `mem_write` pulse with `mem_address`=0x10 and `mem_wdata`=0xA5.
  - The load returns `rsp_rdata`=0x00A5 at E2 after acceptance.
- **Wide store then load:** store 0xBEEF at 0x20, then load wide from 0x20.
  - Writes 0xEF@0x20 and 0xBE@0x21, in that order.
  - The load returns 0xBEEF with `rsp_valid` at E4.
- **Wrap:** wide store 0x1234 at 0xFF.
  - Writes 0x34@0xFF and 0x12@0x00.
  - A byte load from 0x00 returns 0x0012.
- **Stray/mismatched ready:**
  - `mem_ready_w` pulsed during a load's WAIT, and `mem_ready_r` pulsed in IDLE, cause no state change.
  - The load completes only on `mem_ready_r`.
- **Reset mid-op:** `reset_n` low during a wide load's second ISSUE.
  - `mem_read`=0 and `req_ready`=1 immediately.
  - No `rsp_valid` is produced.
- **Timeout (macro on, `timeout`=15):** RAM ready held low.
  - `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0x0000 after 15 WAIT cycles.
  - The next request proceeds normally.

Source files
------------

// File: rtl/mem_master.sv
// mem_master: bus initiator that turns byte/16-bit CPU loads and stores into
// one-cycle RAM read/write strobes, waits for the matching ready, and returns
// the assembled little-endian read data with a one-cycle response pulse.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (accepted when both high at an edge)
//   req_we, req_wide        store/load select, 16-bit/byte select
//   req_addr, req_wdata     low-byte address, store data (byte stores use [7:0])
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata, rsp_err      load data (held until next response), timeout flag
//   mem_read, mem_write     one-cycle RAM strobes
//   mem_address, mem_wdata  RAM address and write byte, held through the wait
//   mem_rdata               RAM read byte
//   mem_ready_r/_w          RAM read/write completion
//
// Build option: define MEM_MASTER_TIMEOUT_EN to abort a byte transaction after
// `timeout` wait cycles without a matching ready (rsp_err=1, rsp_rdata=0).
module mem_master #(
    parameter int size_addr = 8,
    parameter int timeout   = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic                 req_wide,
    input  logic [size_addr-1:0] req_addr,
    input  logic [15:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [15:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [size_addr-1:0] mem_address,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_ready_r,
    input  logic                 mem_ready_w
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic                 we_q, we_d, wide_q, wide_d, idx_q, idx_d;
    logic [size_addr-1:0] addr_q, addr_d, mem_address_q, mem_address_d;
    logic [15:0]          wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [7:0]           lo_q, lo_d, mem_wdata_q, mem_wdata_d;
    logic                 req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d, mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic                 hit;

`ifdef MEM_MASTER_TIMEOUT_EN
    localparam int cw = $clog2(timeout + 1);
    logic [cw-1:0] cnt_q, cnt_d;
`else
    // The wait limit only exists when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = timeout != 0;
`endif

    // Only the ready belonging to the issued operation completes it.
    assign hit = we_q ? mem_ready_w : mem_ready_r;

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        wide_d        = wide_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        idx_d         = idx_q;
        lo_d          = lo_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = 1'b0;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                wide_d  = req_wide;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                idx_d   = 1'b0;
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MEM_MASTER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: if (hit) begin
                if (!we_q && !idx_q) lo_d = mem_rdata;
                if (wide_q && !idx_q) begin
                    idx_d   = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = RESP;
                    if (!we_q) rsp_rdata_d = wide_q ? {mem_rdata, lo_q} : {8'h00, mem_rdata};
                end
            end
`ifdef MEM_MASTER_TIMEOUT_EN
            else if (cnt_q == cw'(timeout - 1)) begin
                // Abort the whole access; a pending high byte is never issued.
                state_d     = RESP;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = 16'h0000;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are derived from the state being entered.
        if (state_d == ISSUE) begin
            mem_read_d    = !we_d;
            mem_write_d   = we_d;
            mem_address_d = addr_d + size_addr'(idx_d);
            mem_wdata_d   = idx_d ? wdata_d[15:8] : wdata_d[7:0];
        end
        req_ready_d = state_d == IDLE;
        rsp_valid_d = state_d == RESP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            wide_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            idx_q         <= 1'b0;
            lo_q          <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
`ifdef MEM_MASTER_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            wide_q        <= wide_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            idx_q         <= idx_d;
            lo_q          <= lo_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
`ifdef MEM_MASTER_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed bench for mem_master with a behavioural RAM and a
// transaction-level model (expected RAM operations and responses).
module tb_mem_master;
    typedef struct packed {logic we; logic [7:0] a; logic [7:0] d;} op_t;
    typedef struct packed {logic [15:0] d; logic e;} rsp_t;

    logic        clk = 1'b0;
    logic        reset_n, req_valid, req_ready, req_we, req_wide;
    logic [7:0]  req_addr, mem_address, mem_wdata, mem_rdata;
    logic [15:0] req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_err, mem_read, mem_write;
    logic        ram_rr, ram_rw, stray_r, stray_w;

    logic [7:0]  ram [256];
    logic [7:0]  shadow [256];
    op_t         eops [$];
    rsp_t        ers [$];
    logic [15:0] m_last = 16'h0, obs_last = 16'h0;
    int          ram_lat = 0;
    bit          mute = 1'b0, stray_mode = 1'b0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_master #(.size_addr(8), .timeout(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wide(req_wide),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready_r(ram_rr | stray_r), .mem_ready_w(ram_rw | stray_w)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // RAM: latches a strobe, writes immediately, answers ram_lat+1 cycles later.
    initial begin
        int cnt;
        logic [7:0] a;
        logic w;
        cnt = 0; a = 0; w = 0;
        ram_rr = 0; ram_rw = 0; mem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            ram_rr = 0; ram_rw = 0;
            if (!reset_n) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && !mute) begin
                        if (w) ram_rw = 1;
                        else begin
                            ram_rr = 1;
                            mem_rdata = ram[a];
                        end
                    end
                end
                if (mem_read || mem_write) begin
                    a = mem_address;
                    w = mem_write;
                    if (w) ram[a] = mem_wdata;
                    cnt = ram_lat + 1;
                end
            end
        end
    end

    // Compare process: every cycle, strobes and responses against the model.
    always @(negedge clk) begin
        op_t  o;
        rsp_t r;
        if (!reset_n) begin
            eops.delete();
            ers.delete();
            m_last = 16'h0;
            obs_last = 16'h0;
            chk("reset_outputs", {req_ready, rsp_valid, mem_read, mem_write, rsp_err}, 5'b10000);
        end else begin
            if (mem_read || mem_write) begin
                if (eops.size() == 0) chk("unexpected_strobe", 1, 0);
                else begin
                    o = eops.pop_front();
                    chk("op_write", mem_write, o.we);
                    chk("op_read", mem_read, !o.we);
                    chk("op_addr", mem_address, o.a);
                    if (o.we) chk("op_wdata", mem_wdata, o.d);
                end
            end
            if (rsp_valid) begin
                if (ers.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    r = ers.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.d);
                    chk("rsp_err", rsp_err, r.e);
                    obs_last = r.d;
                end
            end else chk("rdata_hold", rsp_rdata, obs_last);
        end
    end

    task automatic send(input logic we, input logic wide, input logic [7:0] a, input logic [15:0] wd);
        op_t o;
        rsp_t r;
        logic [7:0] a1;
        int n;
        a1 = a + 8'd1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_wait", 0, 1);
        req_valid = 1; req_we = we; req_wide = wide; req_addr = a; req_wdata = wd;
        o.we = we; o.a = a; o.d = wd[7:0];
        eops.push_back(o);
        if (wide && !mute) begin
            o.a = a1; o.d = wd[15:8];
            eops.push_back(o);
        end
        if (mute) r = '{16'h0000, 1'b1};
        else if (we) begin
            shadow[a] = wd[7:0];
            if (wide) shadow[a1] = wd[15:8];
            r = '{m_last, 1'b0};
        end else r = '{wide ? {shadow[a1], shadow[a]} : {8'h00, shadow[a]}, 1'b0};
        m_last = r.d;
        ers.push_back(r);
        @(posedge clk); #1;
        // Request inputs must be ignored once accepted.
        req_valid = 0; req_we = ~we; req_wide = ~wide; req_addr = 8'hC3; req_wdata = 16'h7E7E;
    endtask

    task automatic wait_rsp(output int k, output logic [15:0] rd, output logic e);
        k = 0; rd = 16'hxxxx; e = 1'bx;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("busy_not_ready", req_ready, 0);
            if (stray_mode && k == 2) stray_w = 1;
            if (k == 3) stray_w = 0;
            if (rsp_valid) begin
                rd = rsp_rdata;
                e = rsp_err;
                break;
            end
        end
        if (k >= 200) chk("rsp_wait_expired", 0, 1);
        @(negedge clk);
        chk("ready_after_rsp", req_ready, 1);
    endtask

    logic       tv_we [6]   = '{1, 0, 0, 1, 0, 0};
    logic       tv_wide [6] = '{1, 1, 0, 0, 1, 1};
    logic [7:0] tv_a [6]    = '{8'h40, 8'h40, 8'h41, 8'h42, 8'h41, 8'h80};
    logic [15:0] tv_d [6]   = '{16'hC0DE, 0, 0, 16'hFF77, 0, 0};
    int         tv_lat [6]  = '{1, 2, 0, 2, 1, 0};

    initial begin
        int k;
        logic [15:0] rd;
        logic e;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        reset_n = 1; req_valid = 0; req_we = 0; req_wide = 0; req_addr = 0; req_wdata = 0;
        stray_r = 0; stray_w = 0;
        #1 reset_n = 0;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_addr", mem_address, 0);
        @(negedge clk);
        reset_n = 1;

        send(1, 0, 8'h10, 16'h00A5); wait_rsp(k, rd, e);
        chk("bstore_lat", k, 3);
        chk("bstore_ram", ram[8'h10], 8'hA5);
        send(0, 0, 8'h10, 0); wait_rsp(k, rd, e);
        chk("bload_lat", k, 3);
        chk("bload_data", rd, 16'h00A5);

        send(1, 1, 8'h20, 16'hBEEF); wait_rsp(k, rd, e);
        chk("wstore_lat", k, 5);
        chk("wstore_lo", ram[8'h20], 8'hEF);
        chk("wstore_hi", ram[8'h21], 8'hBE);
        send(0, 1, 8'h20, 0); wait_rsp(k, rd, e);
        chk("wload_lat", k, 5);
        chk("wload_data", rd, 16'hBEEF);

        send(1, 1, 8'hFF, 16'h1234); wait_rsp(k, rd, e);
        chk("wrap_lo", ram[8'hFF], 8'h34);
        chk("wrap_hi", ram[8'h00], 8'h12);
        send(0, 0, 8'h00, 0); wait_rsp(k, rd, e);
        chk("wrap_load", rd, 16'h0012);

        @(negedge clk); stray_r = 1;
        @(negedge clk); stray_r = 0;
        chk("stray_idle_ready", req_ready, 1);
        ram_lat = 3; stray_mode = 1;
        send(0, 0, 8'h20, 0); wait_rsp(k, rd, e);
        chk("stray_lat", k, 6);
        chk("stray_data", rd, 16'h00EF);
        stray_mode = 0; ram_lat = 0;
        send(1, 0, 8'h50, 16'h0033); wait_rsp(k, rd, e);
        chk("store_keeps_rdata", rd, 16'h00EF);

        for (int i = 0; i < 6; i++) begin
            ram_lat = tv_lat[i];
            send(tv_we[i], tv_wide[i], tv_a[i], tv_d[i]); wait_rsp(k, rd, e);
            chk("vec_lat", k, tv_wide[i] ? 2 * tv_lat[i] + 5 : tv_lat[i] + 3);
        end
        ram_lat = 0;
        chk("vec_wide_mixed", rd, 16'hDBDA);

        send(0, 1, 8'h20, 0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("mid_second_issue", mem_read, 1);
        chk("mid_second_addr", mem_address, 8'h21);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_read", mem_read, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_rsp", rsp_valid, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", rsp_valid, 0);
        end
        send(0, 0, 8'h21, 0); wait_rsp(k, rd, e);
        chk("after_rst_load", rd, 16'h00BE);

`ifdef MEM_MASTER_TIMEOUT_EN
        mute = 1;
        send(0, 1, 8'h30, 0); wait_rsp(k, rd, e);
        chk("to_lat", k, 17);
        chk("to_err", e, 1);
        chk("to_data", rd, 16'h0000);
        mute = 0;
        repeat (3) @(negedge clk);
        send(0, 0, 8'h10, 0); wait_rsp(k, rd, e);
        chk("to_next_lat", k, 3);
        chk("to_next_data", rd, 16'h00A5);
        chk("to_next_err", e, 0);
`endif

        repeat (3) @(negedge clk);
        chk("queues_drained", eops.size() + ers.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
